// File: rtl/input_state.sv
// input_state: player-input stage of the memory game.
// Synchronises and debounces the four colour buttons. Each press is checked
// against the latched colour sequence, and a one-cycle complete_input or
// fail_input pulse reports the result.
// Optional build macro INPUT_TIMEOUT_EN adds a per-colour press timeout
// (TIMEOUT_CYCLES). Without it, WAIT_PRESS waits indefinitely.
module input_state #(
   parameter int DEBOUNCE_CYCLES = 4
`ifdef INPUT_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 1000
`endif
) (
   input  logic        clk,
   input  logic        rst_input_n,
   input  logic        en_input,
   input  logic [31:0] seq_in_input,
   input  logic [3:0]  round_ctr,
   input  logic [3:0]  btn_in,
   output logic [1:0]  echo_colour,
   output logic        echo_oe,
   output logic        complete_input,
   output logic        fail_input
);

   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES);
`ifdef INPUT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_PRESS,
      S_WAIT_RELEASE,
      S_PASS,
      S_FAIL
   } state_t;

   state_t         state_q;
   logic [3:0]     sync1_q, sync2_q;
   logic [3:0]     cand_q, btn_db_q;
   logic [DBW-1:0] db_cnt_q, db_cnt_d;
   logic           prev_zero_q;
   logic [31:0]    seq_q;
   logic [3:0]     len_q, idx_q;
   logic [1:0]     echo_colour_q;
   logic           echo_oe_q, complete_q, fail_q;
   logic           press;
   logic [1:0]     press_col;
   logic [1:0]     exp_col;
`ifdef INPUT_TIMEOUT_EN
   logic [TW-1:0]  to_cnt_q;
`endif

   // Count consecutive cycles the synchronised vector has held its value
   always_comb begin
      db_cnt_d = db_cnt_q;
      if (sync2_q != cand_q) begin
         db_cnt_d = DBW'(1);
      end else if (db_cnt_q != DB_MAX) begin
         db_cnt_d = db_cnt_q + 1'b1;
      end
   end

   // Two-flop synchroniser followed by the debounce register
   always_ff @(posedge clk or negedge rst_input_n) begin
      if (!rst_input_n) begin
         sync1_q     <= 4'b0000;
         sync2_q     <= 4'b0000;
         cand_q      <= 4'b0000;
         db_cnt_q    <= '0;
         btn_db_q    <= 4'b0000;
         prev_zero_q <= 1'b0;
      end else begin
         sync1_q     <= btn_in;
         sync2_q     <= sync1_q;
         cand_q      <= sync2_q;
         db_cnt_q    <= db_cnt_d;
         if (db_cnt_d == DB_MAX) begin
            btn_db_q <= sync2_q;
         end
         prev_zero_q <= (btn_db_q == 4'b0000);
      end
   end

   // A press is the debounced vector moving from all-released to exactly one button
   assign press = prev_zero_q && $onehot(btn_db_q);

   // Encode the one-hot button into a colour number
   always_comb begin
      press_col = 2'd0;
      if (btn_db_q[1]) press_col = 2'd1;
      if (btn_db_q[2]) press_col = 2'd2;
      if (btn_db_q[3]) press_col = 2'd3;
   end

   assign exp_col = seq_q[{idx_q, 1'b0} +: 2];

   // Game-input FSM with registered echo and result pulses
   always_ff @(posedge clk or negedge rst_input_n) begin
      if (!rst_input_n) begin
         state_q       <= S_IDLE;
         seq_q         <= 32'd0;
         len_q         <= 4'd0;
         idx_q         <= 4'd0;
         echo_colour_q <= 2'd0;
         echo_oe_q     <= 1'b0;
         complete_q    <= 1'b0;
         fail_q        <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
         to_cnt_q      <= '0;
`endif
      end else begin
         complete_q <= 1'b0;
         fail_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (en_input) begin
                  seq_q   <= seq_in_input;
                  len_q   <= round_ctr;
                  idx_q   <= 4'd0;
                  state_q <= S_WAIT_PRESS;
`ifdef INPUT_TIMEOUT_EN
                  to_cnt_q <= '0;
`endif
               end
            end
            S_WAIT_PRESS: begin
               if (press) begin
                  if (press_col == exp_col) begin
                     echo_colour_q <= press_col;
                     echo_oe_q     <= 1'b1;
                     state_q       <= S_WAIT_RELEASE;
                  end else begin
                     fail_q  <= 1'b1;
                     state_q <= S_FAIL;
                  end
               end
`ifdef INPUT_TIMEOUT_EN
               else if (to_cnt_q == TO_LAST) begin
                  fail_q  <= 1'b1;
                  state_q <= S_FAIL;
               end else begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
`endif
            end
            S_WAIT_RELEASE: begin
               if (btn_db_q == 4'b0000) begin
                  echo_oe_q <= 1'b0;
                  if (idx_q == len_q) begin
                     complete_q <= 1'b1;
                     state_q    <= S_PASS;
                  end else begin
                     idx_q   <= idx_q + 4'd1;
                     state_q <= S_WAIT_PRESS;
`ifdef INPUT_TIMEOUT_EN
                     to_cnt_q <= '0;
`endif
                  end
               end
            end
            S_PASS:  state_q <= S_IDLE;
            S_FAIL:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign echo_colour    = echo_colour_q;
   assign echo_oe        = echo_oe_q;
   assign complete_input = complete_q;
   assign fail_input     = fail_q;

endmodule
